gcd_result_sink: RTL and testbench

// - Output-side partner of the switch/button stimulus wrapper: consumes results from a

---
 rtl/gcd_result_sink_if.sv | 20 ++
 rtl/gcd_result_sink.sv | 133 +++++++++++++
 tb/tb_gcd_result_sink.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_result_sink_if.sv
// Result handshake between an algorithm core (master) and the result sink (slave).
interface gcd_result_sink_if #(
  parameter int N = 8
);
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         res_ready;

  modport master (
    output res_valid,
    output res_data,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    output res_ready
  );
endinterface

// File: rtl/gcd_result_sink.sv
// Captures one core result per request for display, flags requests that time out,
// and counts accepted results; a synchronised button acknowledges the shown result.
module gcd_result_sink #(
  parameter int N       = 8,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                req_valid,
  gcd_result_sink_if.slave    res,
  input  logic                ack_btn,
  output logic [N-1:0]        hold_data,
  output logic                hold_valid,
  output logic                timeout,
  output logic [CW-1:0]       result_count
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_TMO
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ready_q, ready_d;
  logic [N-1:0]    hold_data_q, hold_data_d;
  logic            hold_valid_q, hold_valid_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      ack_sync_q, ack_sync_d;
  logic            ack_pulse;
  logic            accept;

  // Two synchroniser stages, third stage only for rising-edge detection.
  always_comb begin
    ack_sync_d = {ack_sync_q[1:0], ack_btn};
  end

  assign ack_pulse = ack_sync_q[1] & ~ack_sync_q[2];
  assign accept    = res.res_valid & ready_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ready_d      = ready_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    timeout_d    = timeout_q;
    count_d      = count_q;

    if (req_valid) begin
      state_d      = S_WAIT;
      timer_d      = '0;
      ready_d      = 1'b1;
      hold_valid_d = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_d = 1'b0;
        end
        S_WAIT: begin
          // A result on the expiry cycle still counts as on time.
          if (accept) begin
            hold_data_d  = res.res_data;
            hold_valid_d = 1'b1;
            count_d      = (&count_q) ? count_q : count_q + 1'b1;
            ready_d      = 1'b0;
            state_d      = S_HOLD;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            ready_d   = 1'b0;
            state_d   = S_TMO;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_HOLD: begin
          ready_d = 1'b0;
          if (ack_pulse) begin
            hold_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        S_TMO: begin
          ready_d = 1'b0;
          if (ack_pulse) begin
            timeout_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ready_q      <= 1'b0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
      ack_sync_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ready_q      <= ready_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
      ack_sync_q   <= ack_sync_d;
    end
  end

  assign res.res_ready = ready_q;
  assign hold_data     = hold_data_q;
  assign hold_valid    = hold_valid_q;
  assign timeout       = timeout_q;
  assign result_count  = count_q;

endmodule

// File: tb/tb_gcd_result_sink.sv
// Drives two sinks (default and TIMEOUT=4/CW=2) with shared stimulus and compares
// them against a request-level reference model.
module tb_gcd_result_sink;

  localparam int TA   = 1024;
  localparam int TB   = 4;
  localparam int MAXA = 255;
  localparam int MAXB = 3;

  logic clk = 1'b0;
  logic nrst;
  logic req_valid;
  logic ack_btn;

  logic [7:0] hd_a, hd_b;
  logic       hv_a, hv_b, to_a, to_b;
  logic [7:0] rc_a;
  logic [1:0] rc_b;

  gcd_result_sink_if #(.N(8)) ifa ();
  gcd_result_sink_if #(.N(8)) ifb ();

  gcd_result_sink #(.N(8), .TIMEOUT(TA), .CW(8)) dut_a (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .res(ifa), .ack_btn(ack_btn),
    .hold_data(hd_a), .hold_valid(hv_a), .timeout(to_a), .result_count(rc_a)
  );

  gcd_result_sink #(.N(8), .TIMEOUT(TB), .CW(2)) dut_b (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .res(ifb), .ack_btn(ack_btn),
    .hold_data(hd_b), .hold_valid(hv_b), .timeout(to_b), .result_count(rc_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: expected outputs of each sink
  int         cnt_a, cnt_b;
  logic [7:0] eh_a, eh_b;
  logic       ev_a, ev_b, et_a, et_b, er_a, er_b;

  function automatic logic [18:0] obs_a();
    return {hd_a, hv_a, to_a, rc_a, ifa.res_ready};
  endfunction
  function automatic logic [18:0] exp_a();
    return {eh_a, ev_a, et_a, 8'(cnt_a), er_a};
  endfunction
  function automatic logic [12:0] obs_b();
    return {hd_b, hv_b, to_b, rc_b, ifb.res_ready};
  endfunction
  function automatic logic [12:0] exp_b();
    return {eh_b, ev_b, et_b, 2'(cnt_b), er_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic [7:0] d);
    ifa.res_valid = v; ifa.res_data = d;
    ifb.res_valid = v; ifb.res_data = d;
  endtask

  task automatic model_reset();
    cnt_a = 0; cnt_b = 0; eh_a = '0; eh_b = '0;
    ev_a = 0; ev_b = 0; et_a = 0; et_b = 0; er_a = 0; er_b = 0;
  endtask

  // request at edge 0, result offered at edge d+1; accepted iff d+1 <= TIMEOUT
  task automatic run_request(input int d, input logic [7:0] data, input string nm);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ev_a = 0; ev_b = 0;
    for (int k = 0; k <= d; k++) begin
      if (k > 0) tick();
      et_a = (k >= TA); er_a = (k < TA);
      et_b = (k >= TB); er_b = (k < TB);
      total++;
      if (obs_a() !== exp_a()) begin bad++; $display("FAIL %s_wait_a k=%0d got=%h exp=%h", nm, k, obs_a(), exp_a()); end
      total++;
      if (obs_b() !== exp_b()) begin bad++; $display("FAIL %s_wait_b k=%0d got=%h exp=%h", nm, k, obs_b(), exp_b()); end
    end
    set_res(1'b1, data);
    tick();
    set_res(1'b0, 8'h00);
    if (d + 1 <= TA) begin
      cnt_a = (cnt_a < MAXA) ? cnt_a + 1 : MAXA;
      eh_a = data; ev_a = 1; et_a = 0; er_a = 0;
    end
    if (d + 1 <= TB) begin
      cnt_b = (cnt_b < MAXB) ? cnt_b + 1 : MAXB;
      eh_b = data; ev_b = 1; et_b = 0; er_b = 0;
    end
    total++;
    if (obs_a() !== exp_a()) begin bad++; $display("FAIL %s_done_a got=%h exp=%h", nm, obs_a(), exp_a()); end
    total++;
    if (obs_b() !== exp_b()) begin bad++; $display("FAIL %s_done_b got=%h exp=%h", nm, obs_b(), exp_b()); end
  endtask

  // button pressed before edge k clears hold/timeout at edge k+2 only
  task automatic do_ack(input string nm);
    ack_btn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) begin ev_a = 0; ev_b = 0; et_a = 0; et_b = 0; end
      total++;
      if (obs_a() !== exp_a()) begin bad++; $display("FAIL %s_ack_a e=%0d got=%h exp=%h", nm, e, obs_a(), exp_a()); end
      total++;
      if (obs_b() !== exp_b()) begin bad++; $display("FAIL %s_ack_b e=%0d got=%h exp=%h", nm, e, obs_b(), exp_b()); end
    end
    ack_btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0; req_valid = 1'b0; ack_btn = 1'b0;
    set_res(1'b0, 8'h00);
    model_reset();
    repeat (3) tick();
    total++;
    if (obs_a() !== exp_a()) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs_a(), exp_a()); end
    total++;
    if (obs_b() !== exp_b()) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs_b(), exp_b()); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    repeat (20) tick();
    set_res(1'b1, 8'h33);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs_a() !== exp_a()) begin bad++; $display("FAIL idle_a got=%h exp=%h", obs_a(), exp_a()); end
      total++;
      if (obs_b() !== exp_b()) begin bad++; $display("FAIL idle_b got=%h exp=%h", obs_b(), exp_b()); end
    end
    set_res(1'b0, 8'h00);
  endtask

  task automatic test_basic();
    run_request(4, 8'h06, "basic");
    do_ack("basic");
  endtask

  task automatic test_timeout();
    run_request(TA + 6, 8'h77, "timeout");
    do_ack("timeout");
  endtask

  task automatic test_expiry_tie();
    run_request(TB - 1, 8'h9C, "tie");
    do_ack("tie");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      run_request(int'($urandom_range(0, TB - 1)), 8'($urandom), "sat");
    end
    do_ack("sat");
  endtask

  task automatic test_req_res_collide();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    req_valid = 1'b1;
    set_res(1'b1, 8'hEE);
    tick();
    req_valid = 1'b0;
    set_res(1'b0, 8'h00);
    ev_a = 0; ev_b = 0; et_a = 0; et_b = 0;
    for (int k = 0; k <= TB + 1; k++) begin
      if (k > 0) tick();
      er_a = 1'b1;
      et_b = (k >= TB); er_b = (k < TB);
      total++;
      if (obs_a() !== exp_a()) begin bad++; $display("FAIL collide_a k=%0d got=%h exp=%h", k, obs_a(), exp_a()); end
      total++;
      if (obs_b() !== exp_b()) begin bad++; $display("FAIL collide_b k=%0d got=%h exp=%h", k, obs_b(), exp_b()); end
    end
    do_ack("collide");
  endtask

  task automatic test_req_ack();
    run_request(2, 8'h5A, "reqack_pre");
    ack_btn = 1'b1;
    tick(); tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ev_a = 0; ev_b = 0; et_a = 0; et_b = 0; er_a = 1; er_b = 1;
    total++;
    if (obs_a() !== exp_a()) begin bad++; $display("FAIL reqack_a got=%h exp=%h", obs_a(), exp_a()); end
    total++;
    if (obs_b() !== exp_b()) begin bad++; $display("FAIL reqack_b got=%h exp=%h", obs_b(), exp_b()); end
    set_res(1'b1, 8'hC3);
    tick();
    set_res(1'b0, 8'h00);
    cnt_a = (cnt_a < MAXA) ? cnt_a + 1 : MAXA;
    cnt_b = (cnt_b < MAXB) ? cnt_b + 1 : MAXB;
    eh_a = 8'hC3; eh_b = 8'hC3; ev_a = 1; ev_b = 1; er_a = 0; er_b = 0;
    // button still held: no second pulse, result stays shown
    repeat (4) tick();
    ack_btn = 1'b0;
    repeat (3) tick();
    total++;
    if (obs_a() !== exp_a()) begin bad++; $display("FAIL held_btn_a got=%h exp=%h", obs_a(), exp_a()); end
    total++;
    if (obs_b() !== exp_b()) begin bad++; $display("FAIL held_btn_b got=%h exp=%h", obs_b(), exp_b()); end
    do_ack("reqack");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    set_res(1'b1, 8'h42);
    nrst = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs_a() !== exp_a()) begin bad++; $display("FAIL midreset_a got=%h exp=%h", obs_a(), exp_a()); end
    total++;
    if (obs_b() !== exp_b()) begin bad++; $display("FAIL midreset_b got=%h exp=%h", obs_b(), exp_b()); end
    tick();
    set_res(1'b0, 8'h00);
    nrst = 1'b1;
    tick();
    total++;
    if (obs_a() !== exp_a()) begin bad++; $display("FAIL postreset_a got=%h exp=%h", obs_a(), exp_a()); end
    total++;
    if (obs_b() !== exp_b()) begin bad++; $display("FAIL postreset_b got=%h exp=%h", obs_b(), exp_b()); end
    run_request(1, 8'hA5, "afterreset");
    do_ack("afterreset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_request(int'($urandom_range(0, 7)), 8'($urandom), "rand");
      if ($urandom_range(0, 1) == 1) do_ack("rand");
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_timeout();
    test_expiry_tie();
    test_saturate();
    test_req_res_collide();
    test_req_ack();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
